// File: rtl/clock_div_ctrl.sv
// clock_div_ctrl
// Sequences divide-ratio updates for the integer-N clock divider. Two
// requesters are arbitrated round-robin. The winning ratio is driven onto
// o_div_n and held for a settle window so the divider's output-domain
// synchronizer can absorb it. The requester is then acknowledged.
//
// Ports
//   i_clk           undivided source clock (same clock as the divider)
//   i_reset         asynchronous active-high reset
//   i_req0 / i_n0   requester 0: request level and requested ratio
//   i_req1 / i_n1   requester 1: request level and requested ratio
//   o_ack0 / o_ack1 one-cycle completion pulse per requester
//   o_div_n         registered ratio to the divider N input
//   o_busy          high whenever the sequencer is not idle
//
// state    | meaning
// S_IDLE   | arbitrate pending requests
// S_LOAD   | compare latched ratio with current; drive it if different
// S_SETTLE | hold new ratio while the settle counter runs down
// S_DONE   | pulse ack of the granted requester
module clock_div_ctrl #(
  parameter int              SIZE        = 3,
  parameter logic [SIZE-1:0] DEFAULT_N   = SIZE'(2),
  parameter int              SETTLE_MULT = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req0,
  input  logic [SIZE-1:0] i_n0,
  input  logic            i_req1,
  input  logic [SIZE-1:0] i_n1,
  output logic            o_ack0,
  output logic            o_ack1,
  output logic [SIZE-1:0] o_div_n,
  output logic            o_busy
);

  localparam int MULT_W = $clog2(SETTLE_MULT);
  localparam int CNT_W  = SIZE + MULT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SIZE-1:0]   r_div_n;
  logic [SIZE-1:0]   r_pending_n;
  logic              r_grant;
  logic              r_last_grant;
  logic              r_mask;
  logic              r_busy;
  logic [CNT_W-1:0]  r_settle_cnt;

  logic              w_req0_eff;
  logic              w_req1_eff;
  logic              w_grant_en;
  logic              w_grant_id;
  logic [SIZE-1:0]   w_grant_n;
  logic              w_change;
  logic [SIZE-1:0]   w_eff_old;
  logic [SIZE-1:0]   w_eff_new;
  logic [SIZE-1:0]   w_eff_max;
  logic [CNT_W-1:0]  w_settle_len;

  // r_mask is high only in the IDLE cycle right after DONE; r_grant still
  // names the requester just acknowledged, so that one sits out this round.
  assign w_req0_eff = i_req0 & ~(r_mask & ~r_grant);
  assign w_req1_eff = i_req1 & ~(r_mask &  r_grant);

  // Ratios 0 and 1 both mean bypass, so they settle like a ratio of 1.
  assign w_eff_old    = (r_div_n     < SIZE'(2)) ? SIZE'(1) : r_div_n;
  assign w_eff_new    = (r_pending_n < SIZE'(2)) ? SIZE'(1) : r_pending_n;
  assign w_eff_max    = (w_eff_old > w_eff_new) ? w_eff_old : w_eff_new;
  // SETTLE_MULT is a power of two, so the multiply reduces to a shift.
  assign w_settle_len = CNT_W'(w_eff_max) << MULT_W;
  assign w_change     = (r_pending_n != r_div_n);
  assign w_grant_n    = w_grant_id ? i_n1 : i_n0;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_grant_id  = r_grant;
    o_ack0      = 1'b0;
    o_ack1      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req0_eff && w_req1_eff) begin
          w_grant_en = 1'b1;
          w_grant_id = ~r_last_grant;
        end else if (w_req0_eff) begin
          w_grant_en = 1'b1;
          w_grant_id = 1'b0;
        end else if (w_req1_eff) begin
          w_grant_en = 1'b1;
          w_grant_id = 1'b1;
        end
        if (w_grant_en) w_state_nxt = S_LOAD;
      end
      S_LOAD:   w_state_nxt = w_change ? S_SETTLE : S_DONE;
      S_SETTLE: if (r_settle_cnt == '0) w_state_nxt = S_DONE;
      S_DONE: begin
        o_ack0      = ~r_grant;
        o_ack1      =  r_grant;
        w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_div_n      <= DEFAULT_N;
      r_pending_n  <= '0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_mask       <= 1'b0;
      r_busy       <= 1'b0;
      r_settle_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_mask  <= (r_state == S_DONE);
      if (w_grant_en) begin
        r_pending_n  <= w_grant_n;
        r_grant      <= w_grant_id;
        r_last_grant <= w_grant_id;
      end
      if (r_state == S_LOAD && w_change) begin
        r_div_n      <= r_pending_n;
        r_settle_cnt <= w_settle_len - CNT_W'(1);
      end else if (r_state == S_SETTLE && r_settle_cnt != '0) begin
        r_settle_cnt <= r_settle_cnt - CNT_W'(1);
      end
    end
  end

  assign o_div_n = r_div_n;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_clock_div_ctrl.sv
// tb_clock_div_ctrl
// Drives directed request sequences into clock_div_ctrl. Every cycle the
// outputs are compared against a transaction-timeline model: each grant
// books its busy window, div_n change cycle and ack cycle by arithmetic.
// Directed steps also pin latencies to hand-computed literals.
module tb_clock_div_ctrl;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [2:0] n0, n1;
  logic       ack0, ack1, busy;
  logic [2:0] div_n;

  clock_div_ctrl #(.SIZE(3), .DEFAULT_N(3'd2), .SETTLE_MULT(4)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0(req0), .i_n0(n0), .i_req1(req1), .i_n1(n1),
    .o_ack0(ack0), .o_ack1(ack1), .o_div_n(div_n), .o_busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model timeline (cycle numbers; -1 = nothing booked)
  int m_div = 2, m_last = 1;
  int m_busy_from = -1, m_busy_to = -1;
  int m_ack_cyc = -1, m_ack_id = 0;
  int m_div_cyc = -1, m_div_new = 0;
  int m_idle_from = 0, m_mask_cyc = -1, m_mask_id = 0;
  logic s_ack0, s_ack1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int eff(input int n);
    return (n < 2) ? 1 : n;
  endfunction

  // One clock cycle: at the falling edge compare outputs against the model,
  // then let the model arbitrate; return just after the next rising edge.
  task automatic tick();
    int r0, r1, id, nn, len, d;
    @(negedge clk);
    cyc++;
    if (rst) begin
      m_div = 2; m_last = 1;
      m_busy_from = -1; m_busy_to = -1;
      m_ack_cyc = -1; m_div_cyc = -1;
      m_mask_cyc = -1; m_idle_from = cyc + 1;
    end else if (cyc == m_div_cyc) begin
      m_div = m_div_new;
    end
    check("div_n", int'(div_n), m_div);
    check("busy", int'(busy), (cyc >= m_busy_from && cyc <= m_busy_to) ? 1 : 0);
    check("ack0", int'(ack0), (cyc == m_ack_cyc && m_ack_id == 0) ? 1 : 0);
    check("ack1", int'(ack1), (cyc == m_ack_cyc && m_ack_id == 1) ? 1 : 0);
    s_ack0 = ack0;
    s_ack1 = ack1;
    if (!rst && cyc >= m_idle_from) begin
      r0 = (req0 && !(cyc == m_mask_cyc && m_mask_id == 0)) ? 1 : 0;
      r1 = (req1 && !(cyc == m_mask_cyc && m_mask_id == 1)) ? 1 : 0;
      if (r0 + r1 > 0) begin
        id = (r0 == 1 && r1 == 1) ? 1 - m_last : (r0 == 1 ? 0 : 1);
        nn = (id == 1) ? int'(n1) : int'(n0);
        len = 4 * ((eff(m_div) > eff(nn)) ? eff(m_div) : eff(nn));
        d = (nn == m_div) ? 2 : len + 2;
        m_last = id;
        m_busy_from = cyc + 1;
        m_busy_to = cyc + d;
        m_ack_cyc = cyc + d;
        m_ack_id = id;
        m_div_cyc = (nn == m_div) ? -1 : cyc + 2;
        m_div_new = nn;
        m_idle_from = cyc + d + 1;
        m_mask_cyc = cyc + d + 1;
        m_mask_id = id;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_any(input int budget, output int id, output int at);
    id = -1;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (s_ack0 || s_ack1) begin
        id = s_ack1 ? 1 : 0;
        at = cyc;
        break;
      end
    end
    if (id < 0) check("ack_timeout", 0, 1);
  endtask

  task automatic do_req(input int id, input int n, input int exp_rel);
    int t0, gid, at;
    if (id == 0) begin req0 = 1'b1; n0 = 3'(n); end
    else         begin req1 = 1'b1; n1 = 3'(n); end
    t0 = cyc + 1;
    wait_any(100, gid, at);
    check("grant_id", gid, id);
    check("ack_latency", at - t0, exp_rel);
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
    tick();
  endtask

  task automatic do_both(input int v0, input int v1, input int rel0, input int gap1);
    int t0, gid, at0, at1;
    req0 = 1'b1; n0 = 3'(v0);
    req1 = 1'b1; n1 = 3'(v1);
    t0 = cyc + 1;
    wait_any(100, gid, at0);
    check("both_first_id", gid, 0);
    check("both_first_lat", at0 - t0, rel0);
    req0 = 1'b0;
    wait_any(100, gid, at1);
    check("both_second_id", gid, 1);
    check("both_gap", at1 - at0, gap1);
    req1 = 1'b0;
    tick();
  endtask

  initial begin
    int t0, gid, at, a0, acks;
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    n0 = 3'd2; n1 = 3'd2;
    s_ack0 = 1'b0; s_ack1 = 1'b0;
    repeat (3) tick();
    check("rst_div_n", int'(div_n), 2);
    check("rst_busy", int'(busy), 0);
    check("rst_ack0", int'(ack0), 0);
    check("rst_ack1", int'(ack1), 0);

    // First tie after reset goes to req0; req1 follows in the mask cycle.
    rst = 1'b0;
    t0 = cyc + 1;
    wait_any(50, gid, a0);
    check("first_grant_id", gid, 0);
    check("first_ack_lat", a0 - t0, 2);
    req0 = 1'b0;
    wait_any(50, gid, at);
    check("second_grant_id", gid, 1);
    check("min_ack_gap", at - a0, 3);
    req1 = 1'b0;
    tick();

    // Same value: no settle.
    do_req(1, 2, 2);

    // 2 -> 5: L=20, ack in cycle 22, busy low in cycle 23.
    req0 = 1'b1; n0 = 3'd5;
    t0 = cyc + 1;
    wait_any(100, gid, at);
    check("n5_id", gid, 0);
    check("n5_ack_lat", at - t0, 22);
    req0 = 1'b0;
    check("n5_busy_after", int'(busy), 0);
    check("n5_div_n", int'(div_n), 5);
    tick();

    // 5 -> 2 via req1 so the next tie starts from last_grant=1, div_n=2.
    do_req(1, 2, 22);
    do_both(3, 7, 14, 31);
    do_both(7, 7, 2, 3);

    // Bypass codes.
    do_req(0, 2, 30);
    do_req(0, 0, 10);
    do_req(0, 1, 6);
    do_req(1, 2, 10);

    // Reset during SETTLE of a 2 -> 6 change.
    req0 = 1'b1; n0 = 3'd6;
    t0 = cyc + 1;
    acks = 0;
    repeat (8) begin
      tick();
      acks += int'(s_ack0) + int'(s_ack1);
    end
    check("mid_busy", int'(busy), 1);
    check("mid_div_n", int'(div_n), 6);
    rst = 1'b1;
    #1;
    check("async_rst_div_n", int'(div_n), 2);
    repeat (2) begin
      tick();
      acks += int'(s_ack0) + int'(s_ack1);
    end
    rst = 1'b0;
    t0 = cyc + 1;
    wait_any(100, gid, at);
    check("no_ack_in_reset", acks, 0);
    check("rerun_id", gid, 0);
    check("rerun_ack_lat", at - t0, 26);
    req0 = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
